eth_tx_frame_assembler: RTL and testbench

// - Sits between the NoC and the Ethernet MAC TX path. Consumes one NoC message per frame and emits it as a byte stream.
// - Message layout: flit 0 = data_noc_hdr_flit (routing only, discarded); flit 1 = eth_tx_metadata_flit; flits 2.. = payload.
// - Output frame = 14 B header (eth_dst, eth_src, eth_type) followed by payload_size bytes, shifted 14 B across beats.
// - Frames shorter than MIN_FRAME_BYTES are zero-padded; FCS is left to the MAC.

---
 rtl/eth_tx_frame_assembler.sv | 210 +++++++++++++++++++++
 tb/tb_eth_tx_frame_assembler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_assembler.sv
// Turns one NoC message (routing flit, metadata flit, payload flits) into an Ethernet
// byte stream: 14-byte header followed by the payload, zero-padded to the minimum frame length.
// Metadata flit layout, MSB first: eth_dst[47:0], eth_src[47:0], eth_type[15:0], payload_size[15:0].
module eth_tx_frame_assembler #(
    parameter int DATA_W          = 512,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            noc_eth_tx_in_val,
    input  logic [DATA_W-1:0]               noc_eth_tx_in_data,
    output logic                            noc_eth_tx_in_rdy,
    output logic                            eth_tx_out_val,
    output logic [DATA_W-1:0]               eth_tx_out_data,
    output logic                            eth_tx_out_last,
    output logic [$clog2(DATA_W/8)-1:0]     eth_tx_out_padbytes,
    input  logic                            eth_tx_out_rdy
);
    localparam int DATA_B  = DATA_W / 8;
    localparam int PAD_W   = $clog2(DATA_B);
    localparam int HDR_B   = 14;
    localparam int HDR_W   = HDR_B * 8;
    localparam int BODY_W  = DATA_W - HDR_W;
    localparam int LEN_W   = 16;
    localparam int OFF_W   = LEN_W + PAD_W;

    typedef enum logic [2:0] {
        ST_HDR, ST_META, ST_EMIT_ONLY, ST_FIRST, ST_BODY, ST_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [HDR_W-1:0]    hdr_q, hdr_d;
    logic [LEN_W-1:0]    plen_q, plen_d;
    logic [HDR_W-1:0]    carry_q, carry_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic                run_q, run_d;
    logic                out_val_q, out_val_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [PAD_W-1:0]    out_pad_q, out_pad_d;

    logic [LEN_W:0]      frame_len_s, len_s, in_flits_s, out_beats_s;
    logic [PAD_W-1:0]    pad_s;
    logic [OFF_W-1:0]    off_s;
    logic [DATA_W-1:0]   mask_s, beat_data_s;
    logic [LEN_W-1:0]    meta_len_s;
    logic                slot_free_s, in_rdy_s, in_fire_s, load_s, beat_last_s, last_flit_s;

    // Frame sizing and the byte mask that zeroes everything past 14+P in the current beat.
    always_comb begin
        frame_len_s = (LEN_W+1)'(plen_q) + (LEN_W+1)'(HDR_B);
        len_s       = (frame_len_s < (LEN_W+1)'(MIN_FRAME_BYTES)) ? (LEN_W+1)'(MIN_FRAME_BYTES) : frame_len_s;
        in_flits_s  = ((LEN_W+1)'(plen_q) + (LEN_W+1)'(DATA_B-1)) >> PAD_W;
        out_beats_s = (len_s + (LEN_W+1)'(DATA_B-1)) >> PAD_W;
        pad_s       = PAD_W'(0) - len_s[PAD_W-1:0];
        off_s       = {beat_q, {PAD_W{1'b0}}};
        last_flit_s = ((LEN_W+1)'(beat_q) == (in_flits_s - (LEN_W+1)'(1)));
        meta_len_s  = noc_eth_tx_in_data[DATA_W-HDR_W-1 -: LEN_W];
        mask_s      = '0;
        for (int j = 0; j < DATA_B; j++) begin
            mask_s[DATA_W-1-8*j -: 8] = ((off_s + OFF_W'(j)) < OFF_W'(frame_len_s)) ? 8'hFF : 8'h00;
        end
    end

    // Handshake qualifiers; run_q keeps the input closed until the cycle after reset release.
    always_comb begin
        slot_free_s = !out_val_q || eth_tx_out_rdy;
        case (state_q)
            ST_HDR, ST_META:   in_rdy_s = run_q;
            ST_FIRST, ST_BODY: in_rdy_s = run_q && slot_free_s;
            default:           in_rdy_s = 1'b0;
        endcase
        in_fire_s = noc_eth_tx_in_val && in_rdy_s;
    end

    // Next-state, beat assembly and output-register update.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        plen_d      = plen_q;
        carry_d     = carry_q;
        beat_d      = beat_q;
        run_d       = 1'b1;
        load_s      = 1'b0;
        beat_data_s = '0;
        beat_last_s = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (in_fire_s) state_d = ST_META;
                else           state_d = ST_HDR;
            end
            ST_META: begin
                if (in_fire_s) begin
                    hdr_d   = noc_eth_tx_in_data[DATA_W-1 -: HDR_W];
                    plen_d  = meta_len_s;
                    beat_d  = '0;
                    state_d = (meta_len_s == 16'd0) ? ST_EMIT_ONLY : ST_FIRST;
                end else begin
                    state_d = ST_META;
                end
            end
            ST_EMIT_ONLY: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    beat_data_s = {hdr_q, {BODY_W{1'b0}}};
                    beat_last_s = 1'b1;
                    state_d     = ST_HDR;
                end else begin
                    state_d = ST_EMIT_ONLY;
                end
            end
            ST_FIRST: begin
                if (in_fire_s) begin
                    load_s      = 1'b1;
                    beat_data_s = {hdr_q, noc_eth_tx_in_data[DATA_W-1 -: BODY_W]};
                    carry_d     = noc_eth_tx_in_data[HDR_W-1:0];
                    if (out_beats_s == 17'd1) begin
                        beat_last_s = 1'b1;
                        state_d     = ST_HDR;
                    end else if (in_flits_s == 17'd1) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_BODY;
                    end
                end else begin
                    state_d = ST_FIRST;
                end
            end
            ST_BODY: begin
                if (in_fire_s) begin
                    load_s      = 1'b1;
                    beat_data_s = {carry_q, noc_eth_tx_in_data[DATA_W-1 -: BODY_W]};
                    carry_d     = noc_eth_tx_in_data[HDR_W-1:0];
                    if (last_flit_s && (out_beats_s == in_flits_s)) begin
                        beat_last_s = 1'b1;
                        state_d     = ST_HDR;
                    end else if (last_flit_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_BODY;
                    end
                end else begin
                    state_d = ST_BODY;
                end
            end
            ST_DRAIN: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    beat_data_s = {carry_q, {BODY_W{1'b0}}};
                    beat_last_s = 1'b1;
                    state_d     = ST_HDR;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_HDR;
        endcase

        if (load_s) begin
            out_val_d  = 1'b1;
            out_data_d = beat_data_s & mask_s;
            out_last_d = beat_last_s;
            out_pad_d  = beat_last_s ? pad_s : '0;
            beat_d     = beat_q + 16'd1;
        end else if (eth_tx_out_rdy) begin
            out_val_d  = 1'b0;
            out_data_d = '0;
            out_last_d = 1'b0;
            out_pad_d  = '0;
        end else begin
            out_val_d  = out_val_q;
            out_data_d = out_data_q;
            out_last_d = out_last_q;
            out_pad_d  = out_pad_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HDR;
            hdr_q      <= '0;
            plen_q     <= '0;
            carry_q    <= '0;
            beat_q     <= '0;
            run_q      <= 1'b0;
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_pad_q  <= '0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            plen_q     <= plen_d;
            carry_q    <= carry_d;
            beat_q     <= beat_d;
            run_q      <= run_d;
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_pad_q  <= out_pad_d;
        end
    end

    assign noc_eth_tx_in_rdy   = in_rdy_s;
    assign eth_tx_out_val      = out_val_q;
    assign eth_tx_out_data     = out_data_q;
    assign eth_tx_out_last     = out_last_q;
    assign eth_tx_out_padbytes = out_pad_q;
endmodule

// File: tb/tb_eth_tx_frame_assembler.sv
// Randomized bench for eth_tx_frame_assembler: frames are modelled as flat byte arrays
// and cut into expected beats, then compared against the DUT under random handshakes.
module tb_eth_tx_frame_assembler;
    localparam int DATA_W = 512;
    localparam int DATA_B = 64;
    localparam int PAD_W  = 6;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_val;
    logic [DATA_W-1:0]  in_data;
    logic               in_rdy;
    logic               out_val;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;
    logic [PAD_W-1:0]   out_pad;
    logic               out_rdy;

    always #5 clk = ~clk;

    eth_tx_frame_assembler #(.DATA_W(DATA_W), .MIN_FRAME_BYTES(60)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .noc_eth_tx_in_val   (in_val),
        .noc_eth_tx_in_data  (in_data),
        .noc_eth_tx_in_rdy   (in_rdy),
        .eth_tx_out_val      (out_val),
        .eth_tx_out_data     (out_data),
        .eth_tx_out_last     (out_last),
        .eth_tx_out_padbytes (out_pad),
        .eth_tx_out_rdy      (out_rdy)
    );

    typedef struct { logic [DATA_W-1:0] data; logic last; logic [PAD_W-1:0] pad; } beat_t;
    typedef struct { logic [DATA_W-1:0] data; bit is_pay; } flit_t;

    beat_t exp_q[$];
    flit_t in_q[$];
    int    n_checks = 0;
    int    n_passed = 0;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [DATA_W-1:0] rand_wide();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Queue the input flits of one message and the beats the MAC should see for it.
    task automatic add_frame(input int p, input bit directed);
        logic [47:0] dst, src;
        logic [15:0] typ;
        logic [7:0]  pay[];
        logic [7:0]  fb[];
        flit_t       f;
        beat_t       b;
        int          len, nbeats, nin;
        dst = directed ? 48'h02_00_00_00_00_01 : {$urandom, $urandom};
        src = directed ? 48'h02_00_00_00_00_02 : {$urandom, $urandom};
        typ = directed ? 16'h0800 : 16'($urandom);
        pay = new[p];
        for (int i = 0; i < p; i++) pay[i] = directed ? 8'(i + 1) : 8'($urandom);

        f.data = rand_wide(); f.is_pay = 1'b0;
        in_q.push_back(f);
        f.data = rand_wide();
        f.data[DATA_W-1 -: 112] = {dst, src, typ};
        f.data[DATA_W-113 -: 16] = 16'(p);
        in_q.push_back(f);
        nin = (p + DATA_B - 1) / DATA_B;
        for (int k = 0; k < nin; k++) begin
            f.data = rand_wide(); f.is_pay = 1'b1;
            for (int j = 0; j < DATA_B; j++)
                if (k*DATA_B + j < p) f.data[DATA_W-1-8*j -: 8] = pay[k*DATA_B + j];
            in_q.push_back(f);
        end

        len    = (14 + p < 60) ? 60 : 14 + p;
        nbeats = (len + DATA_B - 1) / DATA_B;
        fb     = new[nbeats*DATA_B];
        foreach (fb[i]) fb[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            fb[i]     = dst[47-8*i -: 8];
            fb[6 + i] = src[47-8*i -: 8];
        end
        fb[12] = typ[15:8];
        fb[13] = typ[7:0];
        for (int i = 0; i < p; i++) fb[14 + i] = pay[i];
        for (int bi = 0; bi < nbeats; bi++) begin
            for (int j = 0; j < DATA_B; j++) b.data[DATA_W-1-8*j -: 8] = fb[bi*DATA_B + j];
            b.last = (bi == nbeats - 1);
            b.pad  = b.last ? PAD_W'(nbeats*DATA_B - len) : '0;
            exp_q.push_back(b);
        end
    endtask

    // Drive queued flits and sink beats; rdy_mode 0=random, 1=pattern 1,0,0,1, 2=always ready.
    task automatic run(input int rdy_mode, input int gap_pct, input int stop_beats, input int budget);
        int  cyc = 0, beats = 0, last_cyc = 0;
        bit  in_acc = 1'b0, new_frame = 1'b1;
        bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            if (!in_val || in_acc) begin
                if (in_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                    in_val  = 1'b1;
                    in_data = in_q[0].data;
                end else begin
                    in_val  = 1'b0;
                end
            end
            case (rdy_mode)
                0:       out_rdy = 1'($urandom_range(1));
                1:       out_rdy = pat[cyc % 4];
                default: out_rdy = 1'b1;
            endcase
            @(negedge clk);
            if (out_val) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", out_val, 0);
                end else if (!out_rdy) begin
                    check_val("stall_data", out_data, exp_q[0].data);
                    check_val("stall_last", out_last, exp_q[0].last);
                    if (in_q.size() > 0 && in_q[0].is_pay) check_val("rdy_while_full", in_rdy, 0);
                end else begin
                    check_val("beat_data", out_data, exp_q[0].data);
                    check_val("beat_last", out_last, exp_q[0].last);
                    check_val("beat_pad", out_pad, exp_q[0].pad);
                    if (rdy_mode == 2 && gap_pct == 0 && !new_frame) check_val("beat_gap", cyc - last_cyc, 1);
                    new_frame = exp_q[0].last;
                    last_cyc  = cyc;
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
            in_acc = in_val && in_rdy;
            if (in_acc) void'(in_q.pop_front());
            if (stop_beats > 0 && beats >= stop_beats) break;
            @(posedge clk); #1;
            cyc++;
        end
        in_val = 1'b0;
        if (stop_beats == 0) check_val("drained", exp_q.size() + in_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_val = 1'b0; in_data = '0; out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_val", out_val, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_last", out_last, 0);
        check_val("rst_pad", out_pad, 0);
        check_val("rst_in_rdy", in_rdy, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        add_frame(0, 1'b1);   add_frame(20, 1'b1);  add_frame(50, 1'b1);
        add_frame(51, 1'b1);  add_frame(115, 1'b1); add_frame(130, 1'b0);
        run(2, 0, 0, 2000);

        add_frame(200, 1'b1);
        run(1, 0, 0, 2000);

        for (int i = 0; i < 25; i++) add_frame(int'($urandom_range(0, 300)), 1'b0);
        run(0, 30, 0, 20000);

        add_frame(1500, 1'b0); add_frame(45, 1'b0); add_frame(46, 1'b0);
        run(0, 10, 0, 5000);

        add_frame(200, 1'b1);
        run(2, 0, 2, 2000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_val", out_val, 0);
        check_val("midrst_data", out_data, 0);
        check_val("midrst_last", out_last, 0);
        check_val("midrst_in_rdy", in_rdy, 0);
        exp_q.delete();
        in_q.delete();
        in_val = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        add_frame(20, 1'b1);
        run(0, 0, 0, 2000);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule
